// File: rtl/hs_pkg.sv
// hs_pkg: shared types and sizing helpers for the handshake queue
package hs_pkg;
   typedef enum logic {HS_IDLE, HS_WAIT_READY} hs_state_t;
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/handshake_queue_if.sv
// handshake_queue_if: request and outgoing valid/ready channels plus queue status
interface handshake_queue_if #(parameter int DATA_W = 32, parameter int DEPTH = 4);
   import hs_pkg::*;
   logic                      flush;
   logic                      req_valid;
   logic [DATA_W-1:0]         req_data;
   logic                      req_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic                      out_ready;
   logic [cnt_w(DEPTH)-1:0]   count;
   logic                      err_clr;
   logic                      timeout_err;
   modport master (
      input  flush, req_valid, req_data, out_ready, err_clr,
      output req_ready, out_valid, out_data, count, timeout_err
   );
   modport slave (
      output flush, req_valid, req_data, out_ready, err_clr,
      input  req_ready, out_valid, out_data, count, timeout_err
   );
endinterface

// File: rtl/handshake_watchdog.sv
// handshake_watchdog: counts consecutive stall cycles and raises a sticky error at TIMEOUT
module handshake_watchdog #(parameter int TIMEOUT = 0) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   input  logic clr,
   input  logic err_clr,
   output logic timeout_err
);
   if (TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = &{1'b0, clk, reset, stall, clr, err_clr};
      assign timeout_err = 1'b0;
   end else begin : g_on
      localparam int SW = $clog2(TIMEOUT + 1);
      logic [SW-1:0] stall_cnt_q, stall_cnt_d;
      logic          err_q, err_d, hit;
      always_comb begin
         stall_cnt_d = (clr || !stall) ? '0 :
                       (stall_cnt_q == SW'(TIMEOUT)) ? stall_cnt_q : stall_cnt_q + SW'(1);
         hit = (stall_cnt_d == SW'(TIMEOUT)) && (stall_cnt_q != SW'(TIMEOUT));
         err_d = hit || (err_q && !err_clr);
      end
      always_ff @(posedge clk) begin
         if (reset) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
         end else begin
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
         end
      end
      assign timeout_err = err_q;
   end
endmodule

// File: rtl/handshake_queue.sv
// handshake_queue: DEPTH-entry FIFO presenting requests in order on a valid/ready channel
module handshake_queue
   import hs_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 0
) (
   input logic                clk,
   input logic                reset,
   handshake_queue_if.master  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     count_q, count_d;
   hs_state_t         state_q, state_d;
   logic              push, pop, wd_err;
   assign push = bus.req_valid && bus.req_ready;
   assign pop  = bus.out_valid && bus.out_ready;
   always_comb begin
      mem_d = mem_q;
      if (push && !bus.flush) mem_d[wr_q] = bus.req_data;
      wr_d    = bus.flush ? '0 : wr_q + PW'(push);
      rd_d    = bus.flush ? '0 : rd_q + PW'(pop);
      count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
      state_d = (count_d != '0) ? HS_WAIT_READY : HS_IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         state_q <= HS_IDLE;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end
   // storage needs no reset: out_data is gated while the queue is empty
   always_ff @(posedge clk) mem_q <= mem_d;
   assign bus.req_ready   = (count_q != CW'(DEPTH));
   assign bus.out_valid   = (state_q == HS_WAIT_READY);
   assign bus.out_data    = bus.out_valid ? mem_q[rd_q] : '0;
   assign bus.count       = count_q;
   assign bus.timeout_err = wd_err;
   handshake_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk         (clk),
      .reset       (reset),
      .stall       (bus.out_valid && !bus.out_ready),
      .clr         (bus.flush),
      .err_clr     (bus.err_clr),
      .timeout_err (wd_err)
   );
endmodule

// File: tb/tb_handshake_queue.sv
// tb_handshake_queue: directed scoreboard bench for handshake_queue (DEPTH=4, TIMEOUT=8)
module tb_handshake_queue;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [31:0] exp_q [$];
   handshake_queue_if #(.DATA_W(32), .DEPTH(4)) bus ();
   handshake_queue #(.DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // drive one cycle at negedge, score push/pop against the model, then check count after the edge
   task automatic cycle(input logic v, input logic [31:0] d, input logic r);
      bus.req_valid = v;
      bus.req_data  = d;
      bus.out_ready = r;
      #1;
      if (v && bus.req_ready) exp_q.push_back(d);
      if (bus.out_valid && r) begin
         if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
         else chk("pop_data", bus.out_data, exp_q.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("count", 32'(bus.count), 32'(exp_q.size()));
   endtask
   initial begin
      bus.flush = 0; bus.req_valid = 0; bus.req_data = 0; bus.out_ready = 0; bus.err_clr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_req_ready", 32'(bus.req_ready), 1);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_timeout_err", 32'(bus.timeout_err), 0);
      chk("rst_out_data", bus.out_data, 0);
      cycle(1, 32'hA1, 1);
      chk("lat_out_valid", 32'(bus.out_valid), 1);
      chk("lat_out_data", bus.out_data, 32'hA1);
      cycle(0, 0, 1);
      chk("drain_out_valid", 32'(bus.out_valid), 0);
      for (int i = 0; i < 4; i++) cycle(1, 32'h10 + i, 0);
      chk("full_req_ready", 32'(bus.req_ready), 0);
      cycle(1, 32'h14, 0);
      chk("full_count", 32'(bus.count), 4);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1);
      chk("empty_out_valid", 32'(bus.out_valid), 0);
      cycle(1, 32'h20, 0);
      cycle(1, 32'h21, 0);
      for (int i = 0; i < 10; i++) cycle(1, 32'h22 + i, 1);
      chk("pp_count", 32'(bus.count), 2);
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      cycle(1, 32'h55, 0);
      for (int i = 0; i < 7; i++) cycle(0, 0, 0);
      chk("wd_before", 32'(bus.timeout_err), 0);
      cycle(0, 0, 0);
      chk("wd_set", 32'(bus.timeout_err), 1);
      chk("wd_data_stable", bus.out_data, 32'h55);
      chk("wd_valid_held", 32'(bus.out_valid), 1);
      cycle(0, 0, 0);
      chk("wd_sticky", 32'(bus.timeout_err), 1);
      bus.err_clr = 1'b1;
      cycle(0, 0, 0);
      bus.err_clr = 1'b0;
      chk("wd_clr", 32'(bus.timeout_err), 0);
      cycle(0, 0, 1);
      cycle(1, 32'h66, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0);
      cycle(0, 0, 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
      chk("wd_no_err", 32'(bus.timeout_err), 0);
      for (int i = 0; i < 3; i++) cycle(1, 32'h70 + i, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0);
      chk("wd_pre_flush", 32'(bus.timeout_err), 1);
      bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_data = 32'h99; bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0; bus.req_valid = 1'b0; bus.out_ready = 1'b0;
      exp_q.delete();
      #1;
      chk("flush_out_valid", 32'(bus.out_valid), 0);
      chk("flush_count", 32'(bus.count), 0);
      chk("flush_err_kept", 32'(bus.timeout_err), 1);
      for (int i = 0; i < 3; i++) cycle(1, 32'h80 + i, 0);
      cycle(0, 0, 1);
      reset = 1'b1; bus.req_valid = 1'b1; bus.req_data = 32'h98; bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; bus.req_valid = 1'b0; bus.out_ready = 1'b0;
      exp_q.delete();
      #1;
      chk("mrst_out_valid", 32'(bus.out_valid), 0);
      chk("mrst_count", 32'(bus.count), 0);
      chk("mrst_timeout_err", 32'(bus.timeout_err), 0);
      chk("mrst_req_ready", 32'(bus.req_ready), 1);
      cycle(1, 32'hC3, 0);
      chk("post_rst_data", bus.out_data, 32'hC3);
      cycle(0, 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
